// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and decode helper for the alu_mdu execute unit.
package alu_pkg;

    localparam logic [4:0] ALUOP_NOP    = 5'd0;
    localparam logic [4:0] ALUOP_LUI    = 5'd1;
    localparam logic [4:0] ALUOP_AUIPC  = 5'd2;
    localparam logic [4:0] ALUOP_ADD    = 5'd3;
    localparam logic [4:0] ALUOP_SUB    = 5'd4;
    localparam logic [4:0] ALUOP_BNE    = 5'd5;
    localparam logic [4:0] ALUOP_BLT    = 5'd6;
    localparam logic [4:0] ALUOP_BGE    = 5'd7;
    localparam logic [4:0] ALUOP_BLTU   = 5'd8;
    localparam logic [4:0] ALUOP_BGEU   = 5'd9;
    localparam logic [4:0] ALUOP_SLT    = 5'd10;
    localparam logic [4:0] ALUOP_SLTU   = 5'd11;
    localparam logic [4:0] ALUOP_XOR    = 5'd12;
    localparam logic [4:0] ALUOP_OR     = 5'd13;
    localparam logic [4:0] ALUOP_AND    = 5'd14;
    localparam logic [4:0] ALUOP_SLL    = 5'd15;
    localparam logic [4:0] ALUOP_SRL    = 5'd16;
    localparam logic [4:0] ALUOP_SRA    = 5'd17;
    localparam logic [4:0] ALUOP_MUL    = 5'd18;
    localparam logic [4:0] ALUOP_MULH   = 5'd19;
    localparam logic [4:0] ALUOP_MULHSU = 5'd20;
    localparam logic [4:0] ALUOP_MULHU  = 5'd21;
    localparam logic [4:0] ALUOP_DIV    = 5'd22;
    localparam logic [4:0] ALUOP_DIVU   = 5'd23;
    localparam logic [4:0] ALUOP_REM    = 5'd24;
    localparam logic [4:0] ALUOP_REMU   = 5'd25;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= ALUOP_MUL) && (op <= ALUOP_REMU);
    endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative RV32M datapath: radix-2 shift-add multiply and restoring divide on magnitudes,
// with sign fix-up applied on the final iteration so the result is ready with done.
module alu_md_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic             is_div,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic               busy_q;
    logic [CW-1:0]      cnt_q;
    logic               div_q;
    logic               neg_q;
    logic               hi_q;
    logic [WIDTH-1:0]   d_q;
    logic [2*WIDTH-1:0] p_q;

    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum, shifted, diff;
    logic [2*WIDTH-1:0] p_nx, full;
    logic [WIDTH-1:0]   qr;

    always_comb begin
        sa = a[WIDTH-1] & ((op == ALUOP_MUL) || (op == ALUOP_MULH) || (op == ALUOP_MULHSU) ||
                           (op == ALUOP_DIV) || (op == ALUOP_REM));
        sb = b[WIDTH-1] & ((op == ALUOP_MUL) || (op == ALUOP_MULH) ||
                           (op == ALUOP_DIV) || (op == ALUOP_REM));
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
    end

    // p_q is {partial product, multiplier} for MUL and {remainder, dividend} for DIV.
    always_comb begin
        sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, d_q} : '0);
        shifted = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        diff    = shifted - {1'b0, d_q};
        if (div_q) begin
            p_nx = {(diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]), p_q[WIDTH-2:0],
                    ~diff[WIDTH]};
        end else begin
            p_nx = {sum, p_q[WIDTH-1:1]};
        end
        full = neg_q ? -p_nx : p_nx;
        qr   = hi_q ? p_nx[2*WIDTH-1:WIDTH] : p_nx[WIDTH-1:0];
        if (div_q) begin
            result = neg_q ? -qr : qr;
        end else begin
            result = hi_q ? full[2*WIDTH-1:WIDTH] : full[WIDTH-1:0];
        end
        done = busy_q & (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            div_q  <= is_div;
            // hi_q selects the high product half, or the remainder for divides.
            hi_q   <= is_div ? ((op == ALUOP_REM) || (op == ALUOP_REMU)) : (op != ALUOP_MUL);
            neg_q  <= (is_div && (op == ALUOP_REM)) ? sa : (sa ^ sb);
            d_q    <= is_div ? mag_b : mag_a;
            p_q    <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
        end else if (busy_q) begin
            p_q   <= p_nx;
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// RV32 execute unit: single-cycle ALU plus iterative mul/div, valid/ready on both sides,
// registered result with zero flag, and flush for killing in-flight work.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             zero
);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             zero_q, zero_d;

    logic [SHW-1:0]   sh;
    logic             div_zero, div_ovf, is_div, go_iter, accept, start;
    logic [WIDTH-1:0] res;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;

    assign in_ready  = (state_q == StIdle) & (~ov_q | out_ready) & ~flush;
    assign accept    = in_valid & in_ready;
    assign out_valid = ov_q;
    assign c         = c_q;
    assign zero      = zero_q;

    // Divide corner cases never enter the iterator; they resolve here in one cycle.
    always_comb begin
        sh       = b[SHW-1:0];
        is_div   = (op >= ALUOP_DIV) && (op <= ALUOP_REMU);
        div_zero = (b == '0);
        div_ovf  = (a == MIN) && (b == '1) && ((op == ALUOP_DIV) || (op == ALUOP_REM));
        go_iter  = is_muldiv(op) && !(is_div && (div_zero || div_ovf));
        res      = '0;
        case (op)
            ALUOP_NOP:               res = a;
            ALUOP_LUI:               res = b;
            ALUOP_AUIPC:             res = pc + b;
            ALUOP_ADD:               res = a + b;
            ALUOP_SUB:               res = a - b;
            ALUOP_BNE:               res = WIDTH'(a == b);
            ALUOP_BLT:               res = WIDTH'($signed(a) >= $signed(b));
            ALUOP_BGE:               res = WIDTH'($signed(a) < $signed(b));
            ALUOP_BLTU:              res = WIDTH'(a >= b);
            ALUOP_BGEU:              res = WIDTH'(a < b);
            ALUOP_SLT:               res = WIDTH'($signed(a) < $signed(b));
            ALUOP_SLTU:              res = WIDTH'(a < b);
            ALUOP_XOR:               res = a ^ b;
            ALUOP_OR:                res = a | b;
            ALUOP_AND:               res = a & b;
            ALUOP_SLL:               res = a << sh;
            ALUOP_SRL:               res = a >> sh;
            ALUOP_SRA:               res = $signed(a) >>> sh;
            ALUOP_DIV, ALUOP_DIVU:   res = div_zero ? '1 : MIN;
            ALUOP_REM, ALUOP_REMU:   res = div_zero ? a : '0;
            default:                 res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ov_d    = ov_q;
        c_d     = c_q;
        zero_d  = zero_q;
        start   = 1'b0;
        if (flush) begin
            state_d = StIdle;
            ov_d    = 1'b0;
        end else begin
            if (ov_q && out_ready) begin
                ov_d = 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (go_iter) begin
                            start   = 1'b1;
                            state_d = is_div ? StDiv : StMul;
                        end else begin
                            c_d    = res;
                            zero_d = (res == '0);
                            ov_d   = 1'b1;
                        end
                    end
                end
                StMul, StDiv: begin
                    if (iter_done) begin
                        c_d     = iter_result;
                        zero_d  = (iter_result == '0);
                        ov_d    = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ov_q    <= 1'b0;
            c_q     <= '0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ov_q    <= ov_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
        end
    end

    alu_md_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .start  (start),
        .is_div (is_div),
        .op     (op),
        .a      (a),
        .b      (b),
        .done   (iter_done),
        .result (iter_result)
    );

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed cases plus random traffic, checked every cycle
// against a behavioural model built from plain 64-bit arithmetic and a one-entry pending slot.
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, zero;
    logic [4:0]  op;
    logic [31:0] a, b, pc, c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state: at most one op outstanding, with its value and the cycle it must appear.
    bit          pend = 1'b0;
    logic [31:0] pend_c;
    int          pend_rdy;
    bit          exp_ov, exp_ir;

    localparam logic [31:0] MIN = 32'h8000_0000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_mdu #(
        .WIDTH(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .pc        (pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .zero      (zero)
    );

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, y, p);
        longint sx, sy, uy;
        longint unsigned ux, uyu;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        uy  = longint'({32'h0, y});
        ux  = {32'h0, x};
        uyu = {32'h0, y};
        case (o)
            5'd0:  return x;
            5'd1:  return y;
            5'd2:  return p + y;
            5'd3:  return x + y;
            5'd4:  return x - y;
            5'd5:  return {31'b0, x == y};
            5'd6:  return {31'b0, sx >= sy};
            5'd7:  return {31'b0, sx < sy};
            5'd8:  return {31'b0, x >= y};
            5'd9:  return {31'b0, x < y};
            5'd10: return {31'b0, sx < sy};
            5'd11: return {31'b0, x < y};
            5'd12: return x ^ y;
            5'd13: return x | y;
            5'd14: return x & y;
            5'd15: return x << y[4:0];
            5'd16: return x >> y[4:0];
            5'd17: return 32'(sx >>> y[4:0]);
            5'd18: return 32'(sx * sy);
            5'd19: return 32'((sx * sy) >>> 32);
            5'd20: return 32'((sx * uy) >>> 32);
            5'd21: return 32'((ux * uyu) >> 32);
            5'd22: return (y == 0) ? 32'hFFFF_FFFF :
                          ((x == MIN && y == 32'hFFFF_FFFF) ? MIN : 32'(sx / sy));
            5'd23: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            5'd24: return (y == 0) ? x : ((x == MIN && y == 32'hFFFF_FFFF) ? 32'h0 : 32'(sx % sy));
            5'd25: return (y == 0) ? x : x % y;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int latency(input logic [4:0] o, input logic [31:0] x, y);
        bit special;
        special = (o >= 5'd22) && (o <= 5'd25) &&
                  ((y == 0) || ((o == 5'd22 || o == 5'd24) && x == MIN && y == 32'hFFFF_FFFF));
        return ((o >= 5'd18) && (o <= 5'd25) && !special) ? 33 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        exp_ov = pend && (cyc >= pend_rdy);
        exp_ir = !flush && (!pend || (exp_ov && out_ready));
        if (!rst) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
            chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
            if (exp_ov) begin
                chk("c", c, pend_c);
                chk("zero", {31'b0, zero}, {31'b0, pend_c == 0});
            end
        end
        if (rst || flush) begin
            pend = 1'b0;
        end else begin
            if (exp_ov && out_ready) pend = 1'b0;
            if (in_valid && exp_ir) begin
                pend     = 1'b1;
                pend_c   = model(op, a, b, pc);
                pend_rdy = cyc + latency(op, a, b);
            end
        end
    end

    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        bit got;
        op = o; a = x; b = y; pc = $urandom; in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for op %0d, required 1", o);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0; pc = '0;
        ticks(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_c", c, 32'h0);
        chk("reset_zero", {31'b0, zero}, 32'h1);
        @(posedge clk); #1;

        // Hand-computed values that pin the model itself.
        chk("model_add", model(5'd3, 32'd5, 32'd7, 32'h0), 32'd12);
        chk("model_bne", model(5'd5, 32'h10, 32'h10, 32'h0), 32'd1);
        chk("model_blt", model(5'd6, 32'hFFFF_FFFF, 32'd1, 32'h0), 32'd0);
        chk("model_sra", model(5'd17, MIN, 32'h21, 32'h0), 32'hC000_0000);
        chk("model_mul", model(5'd18, 32'hFFFF_FFFD, 32'd7, 32'h0), 32'hFFFF_FFEB);
        chk("model_mulh", model(5'd19, 32'hFFFF_FFFD, 32'd7, 32'h0), 32'hFFFF_FFFF);
        chk("model_mulhu", model(5'd21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0), 32'hFFFF_FFFE);
        chk("model_div", model(5'd22, 32'hFFFF_FFF9, 32'd2, 32'h0), 32'hFFFF_FFFD);
        chk("model_rem", model(5'd24, 32'hFFFF_FFF9, 32'd2, 32'h0), 32'hFFFF_FFFF);
        chk("model_divovf", model(5'd22, MIN, 32'hFFFF_FFFF, 32'h0), MIN);
        chk("model_remu0", model(5'd25, 32'd100, 32'd0, 32'h0), 32'd100);
        chk("model_lat_div0", latency(5'd23, 32'd100, 32'd0), 32'd1);

        // Directed traffic; back-to-back single-cycle ops first.
        issue(5'd3, 32'd5, 32'd7);
        issue(5'd3, 32'd1, 32'd2);
        issue(5'd4, 32'd3, 32'd3);
        issue(5'd5, 32'h10, 32'h10);
        issue(5'd6, 32'hFFFF_FFFF, 32'd1);
        issue(5'd17, MIN, 32'h21);
        issue(5'd2, 32'h0, 32'h40);
        issue(5'd28, 32'd9, 32'd9);
        issue(5'd18, 32'hFFFF_FFFD, 32'd7);
        issue(5'd19, 32'hFFFF_FFFD, 32'd7);
        issue(5'd21, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(5'd20, 32'hFFFF_FFFF, 32'd2);
        issue(5'd23, 32'd100, 32'd0);
        issue(5'd25, 32'd100, 32'd0);
        issue(5'd22, MIN, 32'hFFFF_FFFF);
        issue(5'd24, MIN, 32'hFFFF_FFFF);
        issue(5'd22, 32'hFFFF_FFF9, 32'd2);
        issue(5'd24, 32'hFFFF_FFF9, 32'd2);
        issue(5'd23, 32'hDEAD_BEEF, 32'd13);
        ticks(40);

        // Backpressure: result held three cycles while the next op waits.
        out_ready = 1'b0;
        issue(5'd3, 32'd9, 32'd9);
        fork
            begin
                ticks(4);
                out_ready = 1'b1;
            end
        join_none
        issue(5'd12, 32'hF0F0_F0F0, 32'hFF00_FF00);
        ticks(3);

        // Flush mid-divide, then reset mid-multiply; neither may produce a result.
        issue(5'd22, 32'd1000, 32'd7);
        ticks(9);
        flush = 1'b1;
        ticks(1);
        flush = 1'b0;
        ticks(40);
        issue(5'd18, 32'd123, 32'd456);
        ticks(4);
        rst = 1'b1;
        ticks(1);
        rst = 1'b0;
        ticks(40);
        issue(5'd3, 32'd40, 32'd2);
        ticks(3);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      op = 5'($urandom_range(0, 17));
            else if (r < 70) op = 5'($urandom_range(26, 31));
            else             op = 5'($urandom_range(18, 25));
            a         = rand_operand();
            b         = rand_operand();
            pc        = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            ticks(1);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ticks(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised next-generation execute unit for the RV32 core.
- Keeps every existing ALU opcode and adds the RV32M multiply/divide ops, computed iteratively.
- Single-cycle ops return a registered result one cycle after acceptance. MUL/DIV ops take WIDTH+1 cycles.
- Valid/ready handshakes on input and output let the pipeline stall the EX stage cleanly. A flush input kills in-flight work on branch mispredict.

Parameters:
- WIDTH, 32: operand/result width; power of two, ≥8.
- SHW, $clog2(WIDTH): shift-amount bits taken from b.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  abort current op, drop pending result.
- in_valid  in  1  op/a/b/pc valid.
- in_ready  out  1  unit can accept this cycle.
- op  in  5  operation code (shared package).
- a  in  WIDTH  operand A (rs1).
- b  in  WIDTH  operand B (rs2/imm).
- pc  in  WIDTH  instruction PC, used by auipc.
- out_valid  out  1  c/zero valid.
- out_ready  in  1  consumer takes result.
- c  out  WIDTH  result.
- zero  out  1  (c == 0), registered alongside c.

Behaviour:
- Reset values: out_valid=0, c=0, zero=1, state=IDLE; in_ready is 1 in the first cycle after reset.
- Handshakes:
  - Accept when in_valid & in_ready.
  - in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush.
  - Result held stable while out_valid & !out_ready.
- Opcodes 0–17 keep the existing encodings and semantics:
  - nop→a; lui→b; auipc→pc+b; add; sub.
  - Branch ops give c=1 when the branch is NOT taken (bne: a==b; blt: a>=b s; bge: a<b s; bltu/bgeu unsigned), so zero=1 means taken.
  - slt/sltu; xor/or/and.
- Shift rule (new): sll/srl/sra shift by b[SHW-1:0] only. sra is arithmetic.
- New opcodes:
  - 18 mul, 19 mulh, 20 mulhsu, 21 mulhu.
  - 22 div, 23 divu, 24 rem, 25 remu.
  - 26–31 illegal: c=0, 1-cycle latency.
- FSM states: IDLE, MUL, DIV.
  - IDLE: on accept of a single-cycle op, c/zero/out_valid are written at the next edge; state stays IDLE.
  - IDLE→MUL or DIV on accept of a mul/div op. Operands are registered and sign-conditioned (abs values plus a result-sign flag).
  - MUL: radix-2 shift-add over the magnitudes, 2·WIDTH-bit product, WIDTH iterations. Then negate if needed, select low (mul) or high (mulh*) half, set out_valid, →IDLE.
  - DIV: restoring division, WIDTH iterations. Then apply quotient/remainder signs (remainder takes the sign of the dividend), set out_valid, →IDLE.
- Latency: accept in cycle N; MUL/DIV result out_valid in cycle N+WIDTH+1 (33 for WIDTH=32).
- Divide special cases resolve in IDLE with 1-cycle latency, no iteration:
  - b==0: div/divu→all ones; rem/remu→a.
  - Signed overflow (a=MIN, b=-1): div→MIN; rem→0.
- flush: top priority after rst.
  - Next edge: state=IDLE, out_valid=0, iteration counter cleared; c is not updated.
  - An input presented in the flush cycle is not accepted.
- rst mid-operation: identical to the reset state. No partial result ever appears.
- Results are accepted and produced strictly in order. At most one op is in flight.

Decomposition:
- Package alu_pkg:
  - ALUOP_* localparams (5-bit, codes 0–25).
  - FSM state enum.
  - Helper function is_muldiv(op).
- Sub-module alu_md_iter holds the iterative mul/div datapath: magnitudes, counter, partial product or remainder, sign fix-up.
  - Interface: start, is_div, op select, a, b, flush, done, result.
- The top level holds the single-cycle combinational ALU, the handshakes, and the output register.

Test Plan:
- add a=5, b=7, in_valid=1, out_ready=1 → cycle+1: out_valid=1, c=12, zero=0; in_ready stays 1 and back-to-back ops retire every cycle.
- bne a=b=0x10 → c=1, zero=0. blt a=-1, b=1 → c=0, zero=1. sra a=0x80000000, b=0x21 → c=0xC0000000 (shift by 1).
- mul a=0xFFFFFFFD (−3), b=7 → after 33 cycles c=0xFFFFFFEB. mulh same operands → 0xFFFFFFFF. mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. in_ready=0 throughout.
- divu 100/0 → 1 cycle, c=0xFFFFFFFF. remu 100/0 → 100. div 0x80000000/−1 → 0x80000000. rem same → 0. div −7/2 → −3 (0xFFFFFFFD). rem −7/2 → −1.
- Backpressure: out_ready=0 for 3 cycles after result → c/zero/out_valid stable, in_ready=0; release → accepted and next op taken the same cycle.
- flush at cycle 10 of a div, then rst at cycle 5 of a mul → out_valid never rises for either; in_ready=1 the next cycle; a following add returns the correct value.
